// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the loader/debug port.
// Round-robin grant in IDLE, MEM_LAT-cycle ACCESS, one DONE cycle; pipeline stalled until its DONE.
module dmem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_mem_read,
    input  logic        pipe_mem_write,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    output logic [31:0] pipe_rdata,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] ld_rdata,
    output logic        ld_rvalid,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        owner_ld_q;
    logic        prio_ld_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        ld_rvalid_q;

    logic        pipe_req;
    logic        grant_ld;
    logic        grant_pipe;
    logic        we_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;

    // A simultaneous read+write from the MEM stage is treated as a store.
    assign pipe_req   = pipe_mem_read | pipe_mem_write;
    assign grant_ld   = (state_q == S_IDLE) & ld_valid & (~pipe_req | prio_ld_q);
    assign grant_pipe = (state_q == S_IDLE) & pipe_req & ~grant_ld;

    assign we_d    = grant_ld ? ld_we    : pipe_mem_write;
    assign addr_d  = grant_ld ? ld_addr  : pipe_addr;
    assign wdata_d = grant_ld ? ld_wdata : pipe_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            owner_ld_q  <= 1'b0;
            prio_ld_q   <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ld_rvalid_q <= 1'b0;
        end else begin
            ld_rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_ld | grant_pipe) begin
                        state_q     <= S_ACCESS;
                        cnt_q       <= 4'(MEM_LAT - 1);
                        owner_ld_q  <= grant_ld;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        mem_read_q  <= ~we_d;
                        mem_write_q <= we_d;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_DONE;
                        rdata_q     <= mem_rdata;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        ld_rvalid_q <= owner_ld_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    // Next contested grant goes to whoever did not just own the memory.
                    prio_ld_q <= ~owner_ld_q;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pipe_stall = rst_n & pipe_req & ~((state_q == S_DONE) & ~owner_ld_q);
    assign ld_ready   = rst_n & grant_ld;
    assign pipe_rdata = rdata_q;
    assign ld_rdata   = rdata_q;
    assign ld_rvalid  = ld_rvalid_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT 2, 4, 1), each with its own memory,
// transaction-level reference model, directed scenarios and randomized two-requester traffic.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic chk(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL L%0d %s: got %h expected %h", lat, nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_lat
        localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);

        logic        rst_n, pipe_mem_read, pipe_mem_write, pipe_stall;
        logic        ld_valid, ld_ready, ld_we, ld_rvalid, mem_read, mem_write;
        logic [31:0] pipe_addr, pipe_wdata, pipe_rdata, ld_addr, ld_wdata, ld_rdata;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;

        logic [31:0] ext_mem [256];
        logic [31:0] ref_mem [256];
        bit          init_done = 1'b0;
        bit          m_busy, m_own, m_we, m_fav_ld, prev_strb;
        int          m_k;
        logic [31:0] m_addr, m_wdata, m_rd;
        logic [31:0] dut_seq [$];

        assign mem_rdata = ext_mem[mem_addr[9:2]];

        dmem_arbiter #(.MEM_LAT(L)) dut (
            .clk(clk), .rst_n(rst_n),
            .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write),
            .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
            .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
            .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we),
            .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
            .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        // Model: a transaction occupies grant cycle k=0, access cycles k=1..L, done cycle k=L+1.
        always @(negedge clk) begin : model
            logic pr, g_ld, g_pipe, acc, dn, strb;
            if (!init_done) begin
                for (int i = 0; i < 256; i++) begin
                    ext_mem[i] = 32'h3000_0000 + 32'(i) * 32'h0001_0101;
                    ref_mem[i] = ext_mem[i];
                end
                ext_mem[16] = 32'hDEAD_BEEF;
                ref_mem[16] = 32'hDEAD_BEEF;
                init_done = 1'b1;
            end
            strb = mem_read | mem_write;
            if (!rst_n) begin
                chk(L, "rst_pipe_stall", 32'(pipe_stall), 0);
                chk(L, "rst_ld_ready", 32'(ld_ready), 0);
                chk(L, "rst_mem_read", 32'(mem_read), 0);
                chk(L, "rst_mem_write", 32'(mem_write), 0);
                chk(L, "rst_ld_rvalid", 32'(ld_rvalid), 0);
                chk(L, "rst_mem_addr", mem_addr, 0);
                chk(L, "rst_mem_wdata", mem_wdata, 0);
                chk(L, "rst_rdata", pipe_rdata, 0);
                m_busy = 1'b0; m_k = 0; m_fav_ld = 1'b0; m_addr = '0; m_wdata = '0;
                m_own = 1'b0; m_we = 1'b0;
            end else begin
                pr     = pipe_mem_read | pipe_mem_write;
                g_ld   = !m_busy && ld_valid && (!pr || m_fav_ld);
                g_pipe = !m_busy && pr && !g_ld;
                acc    = m_busy && (m_k <= L);
                dn     = m_busy && (m_k == L + 1);
                chk(L, "ld_ready", 32'(ld_ready), 32'(g_ld));
                chk(L, "pipe_stall", 32'(pipe_stall), 32'(pr && !(dn && !m_own)));
                chk(L, "mem_read", 32'(mem_read), 32'(acc && !m_we));
                chk(L, "mem_write", 32'(mem_write), 32'(acc && m_we));
                chk(L, "mem_addr", mem_addr, m_addr);
                chk(L, "mem_wdata", mem_wdata, m_wdata);
                chk(L, "ld_rvalid", 32'(ld_rvalid), 32'(dn && m_own));
                if (dn && !m_we) begin
                    chk(L, "pipe_rdata", pipe_rdata, m_rd);
                    chk(L, "ld_rdata", ld_rdata, m_rd);
                end
                if (strb && !prev_strb) dut_seq.push_back(mem_addr);
                if (mem_write) ext_mem[mem_addr[9:2]] = mem_wdata;
                if (m_busy) begin
                    if (m_k == L + 1) begin
                        m_busy   = 1'b0;
                        m_fav_ld = !m_own;
                        if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
                    end else begin
                        m_k++;
                    end
                end else if (g_ld || g_pipe) begin
                    m_busy  = 1'b1;
                    m_k     = 1;
                    m_own   = g_ld;
                    m_we    = g_ld ? ld_we : pipe_mem_write;
                    m_addr  = g_ld ? ld_addr : pipe_addr;
                    m_wdata = g_ld ? ld_wdata : pipe_wdata;
                    m_rd    = ref_mem[m_addr[9:2]];
                end
            end
            prev_strb = strb;
        end

        task automatic pipe_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                               output int n_stall, output int n_rd, output int n_wr, output logic [31:0] rdata);
            bit got;
            got = 1'b0; n_stall = 0; n_rd = 0; n_wr = 0; rdata = '0;
            pipe_mem_read = rd; pipe_mem_write = wr; pipe_addr = a; pipe_wdata = d;
            for (int c = 0; c < 80 && !got; c++) begin
                @(negedge clk);
                n_stall += int'(pipe_stall);
                n_rd    += int'(mem_read);
                n_wr    += int'(mem_write);
                if (!pipe_stall) begin
                    got   = 1'b1;
                    rdata = pipe_rdata;
                end
            end
            chk(L, "pipe_op_completes", 32'(got), 1);
            @(posedge clk);
            #1;
            pipe_mem_read = 1'b0; pipe_mem_write = 1'b0;
        endtask

        task automatic ld_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                             output int n_rdy, output int n_wr, output logic [31:0] rdata);
            bit got, accepted;
            got = 1'b0; accepted = 1'b0; n_rdy = 0; n_wr = 0; rdata = '0;
            ld_valid = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
            for (int c = 0; c < 80 && !got; c++) begin
                @(negedge clk);
                if (ld_ready) begin
                    n_rdy++;
                    accepted = 1'b1;
                end
                n_wr += int'(mem_write);
                if (ld_rvalid) begin
                    got   = 1'b1;
                    rdata = ld_rdata;
                end
                @(posedge clk);
                #1;
                if (accepted) ld_valid = 1'b0;
            end
            chk(L, "ld_op_completes", 32'(got), 1);
        endtask

        initial begin : stim
            int s, r, w, n, n2, w2;
            logic [31:0] rd, rd2;
            logic [31:0] exp_seq [4];
            rst_n = 1'b0; pipe_mem_read = 1'b1; pipe_mem_write = 1'b0; pipe_addr = 32'h40; pipe_wdata = '0;
            ld_valid = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
            repeat (2) @(posedge clk);
            #1;
            chk(L, "reset_stall_forced_low", 32'(pipe_stall), 0);
            chk(L, "reset_ready_forced_low", 32'(ld_ready), 0);
            pipe_mem_read = 1'b0; ld_valid = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;

            // Pipeline load of the preset word.
            pipe_op(1'b1, 1'b0, 32'h40, 32'h0, s, r, w, rd);
            chk(L, "load_stall_cycles", s, L + 1);
            chk(L, "load_read_cycles", r, L);
            chk(L, "load_data", rd, 32'hDEAD_BEEF);

            // Loader write, then pipeline read-back.
            ld_op(1'b1, 32'h80, 32'h1234_5678, n, w, rd);
            chk(L, "ld_ready_cycles", n, 1);
            chk(L, "ld_write_cycles", w, L);
            pipe_op(1'b1, 1'b0, 32'h80, 32'h0, s, r, w, rd);
            chk(L, "readback_loader_write", rd, 32'h1234_5678);

            // Simultaneous read+write is a store.
            pipe_op(1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, s, r, w, rd);
            chk(L, "rw_write_cycles", w, L);
            chk(L, "rw_read_cycles", r, 0);
            chk(L, "store_stall_cycles", s, L + 1);
            pipe_op(1'b1, 1'b0, 32'h10, 32'h0, s, r, w, rd);
            chk(L, "readback_rw", rd, 32'hA5A5_A5A5);

            // Reset during ACCESS (priority currently favours the loader).
            pipe_mem_read = 1'b1; pipe_addr = 32'h40;
            n = 0;
            for (int c = 0; c < 20 && n == 0; c++) begin
                @(negedge clk);
                n = int'(mem_read);
            end
            chk(L, "abort_access_seen", n, 1);
            if (L >= 2) begin
                @(posedge clk);
                #2;
            end else begin
                #1;
            end
            rst_n = 1'b0;
            #1;
            chk(L, "abort_mem_read", 32'(mem_read), 0);
            chk(L, "abort_mem_write", 32'(mem_write), 0);
            chk(L, "abort_stall", 32'(pipe_stall), 0);
            pipe_mem_read = 1'b0; ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 32'h24;
            #1;
            chk(L, "abort_ld_ready", 32'(ld_ready), 0);
            ld_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            dut_seq.delete();
            rst_n = 1'b1;
            fork
                pipe_op(1'b1, 1'b0, 32'h20, 32'h0, s, r, w, rd);
                ld_op(1'b0, 32'h24, 32'h0, n2, w2, rd2);
            join
            chk(L, "post_reset_first_grant", (dut_seq.size() > 0) ? dut_seq[0] : 32'hFFFF_FFFF, 32'h20);
            chk(L, "post_reset_ld_data", rd2, 32'h3000_0000 + 32'd9 * 32'h0001_0101);

            // Contention from reset: PIPE, LD, PIPE, LD.
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            dut_seq.delete();
            rst_n = 1'b1;
            fork
                begin
                    pipe_op(1'b1, 1'b0, 32'h100, 32'h0, s, r, w, rd);
                    pipe_op(1'b1, 1'b0, 32'h104, 32'h0, s, r, w, rd);
                end
                begin
                    ld_op(1'b0, 32'h0, 32'h0, n2, w2, rd2);
                    ld_op(1'b0, 32'h4, 32'h0, n2, w2, rd2);
                end
            join
            chk(L, "second_pipe_waits_for_loader", s, 2 * L + 3);
            exp_seq = '{32'h100, 32'h0, 32'h104, 32'h4};
            chk(L, "grant_count", dut_seq.size(), 4);
            for (int i = 0; i < 4; i++)
                chk(L, "grant_order", (i < dut_seq.size()) ? dut_seq[i] : 32'hFFFF_FFFF, exp_seq[i]);

            // Randomized concurrent traffic from both requesters.
            fork
                begin
                    int ps, pr_, pw;
                    logic [31:0] prd;
                    for (int k = 0; k < 30; k++) begin
                        logic [1:0] op;
                        op = 2'($urandom_range(0, 2));
                        pipe_op(op != 2'd1, op != 2'd0, 32'($urandom_range(0, 63)) << 2, $urandom,
                                ps, pr_, pw, prd);
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                begin
                    int lr, lw;
                    logic [31:0] lrd;
                    for (int k = 0; k < 30; k++) begin
                        ld_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom,
                              lr, lw, lrd);
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            join
            n_done++;
        end
    end

    initial begin
        fork
            wait (n_done == 3);
            #200000;
        join_any
        chk(0, "all_instances_done", n_done, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (memRead/memWrite from the EX/MEM register) and a loader/debug port used to preload or inspect data memory. It runs every access as a multi-cycle transaction of fixed memory latency, and stalls the pipeline while a MEM-stage access is outstanding. Arbitration is round-robin between the two requesters. The block sits between the MEM stage and data memory, replacing the direct memRead/memWrite connection.

## Interface
Parameters:
- MEM_LAT, default 2: cycles the memory needs per access. Legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pipe_mem_read  input  1  MEM-stage load request (memRead from EX/MEM).
- pipe_mem_write  input  1  MEM-stage store request (memWrite from EX/MEM).
- pipe_addr  input  32  MEM-stage address (ALU result).
- pipe_wdata  input  32  MEM-stage store data.
- pipe_stall  output  1  holds PC, IF/ID, ID/EX and EX/MEM; MEM/WB inserts a bubble.
- pipe_rdata  output  32  load data, valid in the cycle pipe_stall falls.
- ld_valid  input  1  loader request valid.
- ld_ready  output  1  loader request accepted this cycle.
- ld_we  input  1  1 = write, 0 = read.
- ld_addr  input  32  loader address.
- ld_wdata  input  32  loader write data.
- ld_rdata  output  32  loader read data, valid with ld_rvalid.
- ld_rvalid  output  1  one-cycle completion pulse for reads and writes.
- mem_read  output  1  data-memory read strobe.
- mem_write  output  1  data-memory write strobe.
- mem_addr  output  32  data-memory address.
- mem_wdata  output  32  data-memory write data.
- mem_rdata  input  32  data-memory read data; valid in the last ACCESS cycle.

## Operation
- pipe_req = pipe_mem_read | pipe_mem_write. If both are high, the request is a write.
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE:**
  - If one requester is pending, grant it.
  - If both are pending, grant the requester that did not win the last grant. The priority flag resets to favour the pipeline.
  - On a grant: latch addr, wdata, we and owner; load cnt = MEM_LAT-1; go to ACCESS.
  - ld_ready = (state==IDLE) & ld_valid & loader-granted. This is combinational; the loader transfer occurs when ld_valid & ld_ready.
- **ACCESS:**
  - mem_read = ~we_q and mem_write = we_q, held for all MEM_LAT cycles.
  - mem_addr and mem_wdata are driven from the latched values and stay stable.
  - If cnt==0: capture mem_rdata into rdata_q (writes capture too; the value is don't-care) and go to DONE. Otherwise decrement cnt.
- **DONE:**
  - Strobes are low.
  - If owner is the loader, ld_rvalid=1. If owner is the pipeline, pipe_stall is released.
  - Toggle the priority flag to favour the other requester. Go to IDLE.
- pipe_stall = pipe_req & ~(state==DONE & owner==PIPE). It is combinational, so it is also asserted while the loader owns the memory.
- pipe_rdata and ld_rdata both present rdata_q.
- The loader must hold ld_addr, ld_wdata and ld_we stable while ld_valid is high and ld_ready is low.
- Outside ACCESS, mem_addr and mem_wdata hold their last value; they are never X.

## Timing
- Reset (async, immediate):
  - State goes to IDLE, cnt=0, priority favours the pipeline.
  - rdata_q, mem_addr and mem_wdata reset to 0.
  - mem_read, mem_write and ld_rvalid reset to 0.
  - While rst_n is low, pipe_stall and ld_ready are forced to 0.
- Reset mid-ACCESS aborts the transaction: strobes drop and no rvalid or stall release is produced.
- Uncontended access occupies 1 (IDLE) + MEM_LAT (ACCESS) + 1 (DONE) cycles.
  - pipe_stall is high for MEM_LAT+1 cycles and low in DONE; EX/MEM advances on the DONE edge.
  - The pipeline request in the next IDLE belongs to the next instruction.
- Back-to-back requests from the same requester have one IDLE cycle between transactions; throughput is 1 per MEM_LAT+2 cycles.
- With both requesting continuously, grants alternate PIPE, LD, PIPE, …; neither requester waits more than one transaction.
- A request arriving in ACCESS or DONE waits for the next IDLE. The loader sees ld_ready=0; the pipeline sees pipe_stall=1.
- MEM_LAT=1: ACCESS lasts exactly one cycle, and cnt is loaded with 0.

## Test plan
- **Pipeline load, MEM_LAT=2:** preset mem[0x40]=0xDEADBEEF; pipe_mem_read=1, addr 0x40.
  - Required: pipe_stall high for 3 cycles, mem_read high for 2.
  - In DONE: pipe_stall=0 and pipe_rdata=0xDEADBEEF.
- **Loader write, then pipeline read:** loader writes 0x12345678 to 0x80.
  - Required: ld_ready for 1 cycle, mem_write for 2 cycles, ld_rvalid in DONE.
  - A following pipeline read of 0x80 returns 0x12345678.
- **Contention:** pipeline and loader both request from reset, loader reads 0x0 and 0x4 back-to-back.
  - Required grant order: PIPE, LD, PIPE, LD.
  - pipe_stall stays high through the loader transaction.
- **Simultaneous pipe read+write** at 0x10 with data 0xA5A5A5A5.
  - Required: treated as a write (mem_write=1, mem_read=0); a later read returns 0xA5A5A5A5.
- **Reset mid-ACCESS** (MEM_LAT=4, assert rst_n low in the 2nd ACCESS cycle).
  - Required: strobes, pipe_stall and ld_ready are 0 immediately; no ld_rvalid.
  - After release, a pipeline request gets priority.
- **MEM_LAT=1** pipeline store followed by load: each takes 3 cycles, with pipe_stall high for 2 cycles.
